// File: rtl/alu_sequencer.sv
// Valid/ready command sequencer around a combinational 8-bit ALU: operand fetch, execute, AC/E writeback.
// Optional fetch abort on missing mem_ack: define ALU_SEQ_FETCH_TIMEOUT_EN.
module alu_sequencer #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        alu_ac,
    output logic [7:0]        alu_dr,
    output logic [2:0]        alu_sel,
    input  logic [7:0]        alu_result,
    input  logic              alu_e,
    output logic [7:0]        ac,
    output logic              e,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b111;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_req_q;
    logic              done_q;
    logic [7:0]        ac_q, ac_d;
    logic [7:0]        dr_q;
    logic              e_q, e_d;
    logic              fetch_timeout;

    function automatic logic needs_fetch(input logic [2:0] op);
        return !(op == OP_PASS || op == OP_CLR);
    endfunction

    // Writeback values taken at the closing edge of EXEC
    always_comb begin
        ac_d = alu_result;
        e_d  = e_q;
        if (op_q == OP_CLR) begin
            ac_d = '0;
            e_d  = 1'b0;
        end else if (op_q == 3'b000 || op_q == 3'b001 || op_q == 3'b011) begin
            e_d = alu_e;
        end
    end

`ifdef ALU_SEQ_FETCH_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tcnt_q;
    logic          err_q;

    // Limit reached on the last allowed FETCH cycle; a coincident ack still wins
    assign fetch_timeout = (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) && !mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= (state_q == S_FETCH) ? tcnt_q + 1'b1 : '0;
            err_q  <= (state_q == S_FETCH) && fetch_timeout;
        end
    end

    assign err = err_q;
`else
    assign fetch_timeout = 1'b0;
    assign err           = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_PASS;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            done_q     <= 1'b0;
            ac_q       <= '0;
            dr_q       <= '0;
            e_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        mem_addr_q <= cmd_addr;
                        if (needs_fetch(cmd_op)) begin
                            mem_req_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end else begin
                            state_q   <= S_EXEC;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        dr_q      <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= S_EXEC;
                    end else if (fetch_timeout) begin
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_EXEC: begin
                    ac_q    <= ac_d;
                    e_q     <= e_d;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign done      = done_q;
    assign ac        = ac_q;
    assign e         = e_q;
    assign alu_ac    = ac_q;
    assign alu_dr    = dr_q;
    assign alu_sel   = (state_q == S_EXEC && op_q != OP_CLR) ? op_q : OP_PASS;

endmodule
